// File: rtl/sa_local_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sa_local_arb                                                  |
// | Brief    : Input-port local switch-allocation stage. Round-robin picks   |
// |            one VC of this input port, forwards its output-port request   |
// |            to the global allocator, and on grant drives a registered     |
// |            one-hot crossbar select / VC dequeue strobe.                  |
// | Options  : SA_PKT_LOCK_EN - hold the winner for a whole wormhole packet  |
// |            (head to tail). Undefined: flit-level arbitration, busy = 0.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sa_local_arb #(
  parameter int V = 4,  // VCs per input port; crossbar input mux is 4-way
  parameter int P = 5   // router ports
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [V-1:0]   vc_req,
  input  logic [V-1:0]   vc_tail,
  input  logic [V*P-1:0] vc_dst,
  output logic [P-1:0]   sa_req,
  input  logic           sa_gnt,
  output logic [V-1:0]   sel,
  output logic [V-1:0]   vc_pop,
  output logic           busy
);

  localparam int           c_ptr_w = (V > 1) ? $clog2(V) : 1;
  localparam logic [V-1:0] c_one   = {{(V-1){1'b0}}, 1'b1};

  // Pointer successor, wrapping V-1 back to 0.
  function automatic logic [c_ptr_w-1:0] f_next(input logic [c_ptr_w-1:0] v);
    return (int'(v) == V - 1) ? '0 : v + c_ptr_w'(1);
  endfunction

  logic [c_ptr_w-1:0] r_rr_ptr;
  logic [c_ptr_w-1:0] w_rr_ptr_nxt;
  logic [c_ptr_w-1:0] w_rr_pick;
  logic [c_ptr_w-1:0] w_idx;
  logic               w_rr_hit;
  logic [c_ptr_w-1:0] w_winner;
  logic               w_win_valid;
  logic               w_fire;
  logic [P-1:0]       w_dst;
  logic [V-1:0]       r_sel;

  // Round-robin search from r_rr_ptr upwards; scanning backwards lets the
  // nearest requester to the pointer overwrite any farther one.
  always_comb begin
    w_rr_pick = r_rr_ptr;
    w_rr_hit  = 1'b0;
    w_idx     = '0;
    for (int k = V - 1; k >= 0; k--) begin
      w_idx = c_ptr_w'((int'(r_rr_ptr) + k) % V);
      if (vc_req[w_idx]) begin
        w_rr_pick = w_idx;
        w_rr_hit  = 1'b1;
      end
    end
  end

`ifdef SA_PKT_LOCK_EN
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_ptr_w-1:0] r_lock_vc;
  logic [c_ptr_w-1:0] w_lock_vc_nxt;

  // Winner choice and packet-lock next state: a non-tail grant in IDLE locks
  // the VC; while locked only that VC may request, and its tail grant unlocks.
  always_comb begin
    w_state_nxt   = r_state;
    w_lock_vc_nxt = r_lock_vc;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_winner      = w_rr_pick;
    w_win_valid   = w_rr_hit;
    w_fire        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_fire = sa_gnt & w_win_valid;
        if (w_fire) begin
          if (vc_tail[w_winner]) begin
            w_rr_ptr_nxt = f_next(w_winner);
          end else begin
            w_state_nxt   = ST_LOCKED;
            w_lock_vc_nxt = w_winner;
          end
        end
      end
      ST_LOCKED: begin
        w_winner    = r_lock_vc;
        w_win_valid = vc_req[r_lock_vc];
        w_fire      = sa_gnt & w_win_valid;
        if (w_fire && vc_tail[r_lock_vc]) begin
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = f_next(r_lock_vc);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Lock state and locked VC registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_lock_vc <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_vc <= w_lock_vc_nxt;
    end
  end

  assign busy = (r_state == ST_LOCKED);
`else
  // Tail marks only matter for packet locking.
  logic w_unused_tail;
  assign w_unused_tail = ^vc_tail;

  // Flit-level arbitration: every granted flit advances the pointer.
  always_comb begin
    w_winner     = w_rr_pick;
    w_win_valid  = w_rr_hit;
    w_fire       = sa_gnt & w_win_valid;
    w_rr_ptr_nxt = r_rr_ptr;
    if (w_fire) begin
      w_rr_ptr_nxt = f_next(w_winner);
    end
  end

  assign busy = 1'b0;
`endif

  // Output-port lookup for the current winner.
  always_comb begin
    w_dst = '0;
    for (int i = 0; i < V; i++) begin
      if (w_winner == c_ptr_w'(i)) begin
        w_dst = vc_dst[i*P +: P];
      end
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else begin
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // One-cycle select pulse for the crossbar stage following a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel <= '0;
    end else if (w_fire) begin
      r_sel <= c_one << w_winner;
    end else begin
      r_sel <= '0;
    end
  end

  // Request is suppressed while reset is asserted, even with VCs requesting.
  assign sa_req = (w_win_valid && !rst) ? w_dst : '0;
  assign sel    = r_sel;
  assign vc_pop = r_sel;

endmodule
`default_nettype wire
